up_ctrl_unit: RTL

//  Second-generation control unit for the accumulator microprocessor. Multi-cycle FSM
//  (fetch/decode/execute) for a 16-opcode ISA with memory ready-handshake, Enter

---
 rtl/up_cu_pkg.sv | 77 +++++++
 rtl/up_ctrl_unit_if.sv | 9 +
 rtl/up_cu_wdog.sv | 26 ++
 rtl/up_ctrl_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/up_cu_pkg.sv
// up_cu_pkg: state encodings, opcodes and datapath control codes shared by the up_ctrl_unit files
package up_cu_pkg;

    typedef enum logic [4:0] {
        S_START  = 5'b00000,
        S_FETCH  = 5'b00001,
        S_DECODE = 5'b00010,
        S_INREL  = 5'b00011,
        S_IRQ    = 5'b00100,
        S_LOAD   = 5'b10000,
        S_STORE  = 5'b10001,
        S_ADD    = 5'b10010,
        S_SUB    = 5'b10011,
        S_INPUT  = 5'b10100,
        S_JZ     = 5'b10101,
        S_JPOS   = 5'b10110,
        S_HALT   = 5'b10111,
        S_AND    = 5'b11000,
        S_OR     = 5'b11001,
        S_NOT    = 5'b11010,
        S_SHR    = 5'b11011,
        S_SHL    = 5'b11100,
        S_JMP    = 5'b11101,
        S_OUTPUT = 5'b11110,
        S_EXT    = 5'b11111
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'h0;
    localparam logic [3:0] OP_STORE  = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_INPUT  = 4'h4;
    localparam logic [3:0] OP_JZ     = 4'h5;
    localparam logic [3:0] OP_JPOS   = 4'h6;
    localparam logic [3:0] OP_HALT   = 4'h7;
    localparam logic [3:0] OP_AND    = 4'h8;
    localparam logic [3:0] OP_OR     = 4'h9;
    localparam logic [3:0] OP_NOT    = 4'hA;
    localparam logic [3:0] OP_SHR    = 4'hB;
    localparam logic [3:0] OP_SHL    = 4'hC;
    localparam logic [3:0] OP_JMP    = 4'hD;
    localparam logic [3:0] OP_OUTPUT = 4'hE;
    localparam logic [3:0] OP_EXT    = 4'hF;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_NOTA  = 3'b101;
    localparam logic [2:0] ALU_SHR   = 3'b110;
    localparam logic [2:0] ALU_SHL   = 3'b111;

    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_MEM  = 2'b10;

    localparam logic [1:0] JMP_INC   = 2'b00;
    localparam logic [1:0] JMP_IR    = 2'b01;
    localparam logic [1:0] JMP_IRQ   = 2'b10;
    localparam logic [1:0] JMP_RET   = 2'b11;

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        return op == OP_ADD ? ALU_ADD :
               op == OP_SUB ? ALU_SUB :
               op == OP_AND ? ALU_AND :
               op == OP_OR  ? ALU_OR  :
               op == OP_NOT ? ALU_NOTA :
               op == OP_SHR ? ALU_SHR :
               op == OP_SHL ? ALU_SHL : ALU_PASSB;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

endpackage

// File: rtl/up_ctrl_unit_if.sv
// up_ctrl_unit_if: memory request/ready handshake between the control unit and memory
interface up_ctrl_unit_if;
    logic MemReq;
    logic Meminst;
    logic MemWr;
    logic MemReady;
    modport master (output MemReq, Meminst, MemWr, input MemReady);
    modport slave  (input MemReq, Meminst, MemWr, output MemReady);
endinterface

// File: rtl/up_cu_wdog.sv
// up_cu_wdog: counts consecutive stalled memory-wait cycles; expired fires on the TIMEOUT-th one
module up_cu_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            logic [W-1:0] cnt_q, cnt_d;
            // clear outside a wait, count each stalled cycle inside one
            always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
            // stall counter register
            always_ff @(posedge CLOCK or posedge RESET)
                if (RESET) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            assign expired = inc && (cnt_q == W'(TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/up_ctrl_unit.sv
// up_ctrl_unit: fetch/decode/execute control FSM; define UP_CU_IRQ_EN for interrupt entry and RETI
module up_ctrl_unit
    import up_cu_pkg::*;
#(
    parameter int IRW     = 8,
    parameter int TIMEOUT = 15
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic [IRW-1:0] IR,
    input  logic           Aeq0,
    input  logic           Apos,
    input  logic           Enter,
    up_ctrl_unit_if.master mem,
`ifdef UP_CU_IRQ_EN
    input  logic           IRQ,
    output logic           IrqAck,
    output logic           PCsave,
`endif
    output logic           IRload,
    output logic           PCload,
    output logic [1:0]     JMPsel,
    output logic           Aload,
    output logic [2:0]     AluOp,
    output logic [1:0]     Asel,
    output logic           Outload,
    output logic           Halt,
    output logic           Fault,
    output logic [4:0]     outState
);
    state_t state_q, state_d;
    logic   fault_q, fault_d;
    logic   wait_mem, expired;
    logic   ir_unused;
`ifdef UP_CU_IRQ_EN
    logic   in_isr_q, in_isr_d;
`endif

    assign ir_unused = ^IR[IRW-5:0];
    assign wait_mem  = (state_q == S_FETCH) || (state_q[4] && is_mem(state_q[3:0]));
    assign Fault     = fault_q;
    assign outState  = state_q;

    up_cu_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .clr     (!wait_mem),
        .inc     (wait_mem && !mem.MemReady),
        .expired (expired)
    );

    // next state and datapath strobes, decoded from the current state
    always_comb begin
        state_d     = state_q;
        mem.MemReq  = wait_mem;
        mem.Meminst = wait_mem && (state_q != S_FETCH);
        mem.MemWr   = 1'b0;
        IRload      = 1'b0;
        PCload      = 1'b0;
        JMPsel      = JMP_INC;
        Aload       = 1'b0;
        AluOp       = state_q[4] ? alu_of(state_q[3:0]) : ALU_PASSB;
        Asel        = ASEL_ALU;
        Outload     = 1'b0;
        Halt        = 1'b0;
`ifdef UP_CU_IRQ_EN
        IrqAck      = 1'b0;
        PCsave      = 1'b0;
        in_isr_d    = in_isr_q;
`endif
        case (state_q)
`ifdef UP_CU_IRQ_EN
            S_START:  state_d = (IRQ && !in_isr_q) ? S_IRQ : S_FETCH;
            S_IRQ: begin
                PCsave   = 1'b1;
                PCload   = 1'b1;
                JMPsel   = JMP_IRQ;
                IrqAck   = 1'b1;
                in_isr_d = 1'b1;
                state_d  = S_FETCH;
            end
`else
            S_START:  state_d = S_FETCH;
`endif
            S_FETCH: begin
                IRload = mem.MemReady;
                PCload = mem.MemReady;
            end
            S_DECODE: state_d = state_t'({1'b1, IR[IRW-1 -: 4]});
            S_LOAD: begin
                Asel  = ASEL_MEM;
                Aload = mem.MemReady;
            end
            S_STORE:  mem.MemWr = mem.MemReady;
            S_ADD, S_SUB, S_AND, S_OR: Aload = mem.MemReady;
            S_INPUT: begin
                Asel    = ASEL_IN;
                Aload   = Enter;
                state_d = Enter ? S_INREL : S_INPUT;
            end
            S_INREL:  state_d = Enter ? S_INREL : S_START;
            S_JZ: begin
                JMPsel  = JMP_IR;
                PCload  = Aeq0;
                state_d = S_START;
            end
            S_JPOS: begin
                JMPsel  = JMP_IR;
                PCload  = Apos;
                state_d = S_START;
            end
            S_JMP: begin
                JMPsel  = JMP_IR;
                PCload  = 1'b1;
                state_d = S_START;
            end
            S_HALT:   Halt = 1'b1;
            S_NOT, S_SHR, S_SHL: begin
                Aload   = 1'b1;
                state_d = S_START;
            end
            S_OUTPUT: begin
                Outload = 1'b1;
                state_d = S_START;
            end
            S_EXT: begin
`ifdef UP_CU_IRQ_EN
                PCload   = 1'b1;
                JMPsel   = JMP_RET;
                in_isr_d = 1'b0;
`endif
                state_d  = S_START;
            end
            default:  state_d = S_START;
        endcase
        if (wait_mem)
            state_d = mem.MemReady ? ((state_q == S_FETCH) ? S_DECODE : S_START) :
                      expired      ? S_HALT : state_q;
        fault_d = fault_q || expired;
    end

    // state, sticky fault and interrupt-service registers
    always_ff @(posedge CLOCK or posedge RESET)
        if (RESET) begin
            state_q  <= S_START;
            fault_q  <= 1'b0;
`ifdef UP_CU_IRQ_EN
            in_isr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
`ifdef UP_CU_IRQ_EN
            in_isr_q <= in_isr_d;
`endif
        end
endmodule
